dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter that shares the single data memory port between the RISC-V core's load/store path (master 0) and a host/DMA requester (master 1). Sits between the masters and `data_mem` in the top level. It uses fixed core priority with a bounded-starvation rule. Reads are returned to the winning master one cycle after grant through registered data and valid.

## Interface

**Parameters**
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MAX_BURST`, default 4: maximum consecutive master-0 grants while master 1 is waiting. Legal range 1..15.

**Ports** (`n` = 0, 1)
- `i_clk`  in  1: single clock. All state changes on the rising edge.
- `i_rst_n`  in  1: synchronous active-low reset.
- `i_mN_req`  in  1: master n access request, level.
- `i_mN_we`  in  1: master n write enable. 1 = write, 0 = read.
- `i_mN_addr`  in  ADDR_W: master n byte address.
- `i_mN_wdata`  in  DATA_W: master n write data.
- `o_mN_gnt`  out  1: master n is granted this cycle. Combinational.
- `o_mN_rvalid`  out  1: read data for master n is valid. Registered.
- `o_mN_rdata`  out  DATA_W: read data for master n. Registered.
- `o_mem_we`  out  1: to `data_mem` `i_we`.
- `o_mem_addr`  out  ADDR_W: to `data_mem` `i_addr`.
- `o_mem_wdata`  out  DATA_W: to `data_mem` `i_write_data`.
- `i_mem_rdata`  in  DATA_W: from `data_mem` `o_read_data`. Combinational read.

## Operation

**Grant logic** (combinational, from current inputs plus registered state)
- Only m0 requests: grant m0.
- Only m1 requests: grant m1.
- Both request and `burst_cnt < MAX_BURST`: grant m0.
- Both request and `burst_cnt == MAX_BURST`: grant m1.
- Neither requests: no grant.
- At most one `gnt` is high in any cycle.

**Memory port mux**
- The granted master's `we`, `addr` and `wdata` drive the memory port.
- `o_mem_we` = granted `we` AND grant present.
- With no grant: `o_mem_we` = 0; `o_mem_addr` and `o_mem_wdata` = 0.

**Starvation counter `burst_cnt`** (registered, 4 bits)
- Increments, saturating at MAX_BURST, on each m0 grant while `i_m1_req` = 1.
- Clears to 0 on any m1 grant, or on any cycle in which `i_m1_req` = 0.
- Otherwise holds.

**Read return**
- On a granted read (`we` = 0) in cycle T:
  - `i_mem_rdata` is captured into `o_mN_rdata` of the granted master at the edge ending T.
  - `o_mN_rvalid` = 1 for exactly cycle T+1.
- `o_mN_rdata` holds its last value when `rvalid` = 0.
- Writes produce no `rvalid`. The write commits at the edge ending cycle T.

**Handshake**
- A master keeps `req`, `we`, `addr` and `wdata` stable until it sees `gnt` in the same cycle.
- Each cycle with `req` and `gnt` both high is one complete transfer.
- A master may hold `req` high for back-to-back transfers, one per cycle.
- Dropping `req` without `gnt` is allowed. No state is retained for the withdrawn request.

## Timing

**Reset**
- While `i_rst_n` = 0 at a rising edge: `burst_cnt`, both `rvalid` and both `rdata` clear to 0.
- During reset, `gnt` and the memory outputs are forced to 0 regardless of `req`, so no write reaches memory.

**Latency**
- Grant: 0 cycles (combinational).
- Read data: 1 cycle after grant.
- Throughput: one access per cycle total.

**Boundary conditions**
- Reset asserted in the same cycle as a grant: no memory write; `rvalid` is 0 the next cycle.
- Simultaneous request with `burst_cnt` = MAX_BURST: m1 wins; `burst_cnt` → 0. The next contended cycle goes to m0.
- MAX_BURST = 1: under continuous contention, grants strictly alternate m0, m1, m0, m1.
- m1 withdraws `req` mid-wait: `burst_cnt` clears, so the next m1 wait starts fresh.
- Back-to-back reads to the same master: `rvalid` stays high continuously, with new `rdata` each cycle.
- A read granted to m1 immediately after a read granted to m0: `o_m0_rvalid` and `o_m1_rvalid` are high in consecutive cycles, never in the same cycle.

## Test plan

- **Reset:** hold `i_rst_n` = 0 with both `req` = 1 and `we` = 1 → `gnt` = 0, `o_mem_we` = 0, `rvalid` = 0, memory unchanged. Release reset → m0 is granted in the first cycle.
- **Single master:** m1 alone writes 0xDEADBEEF to 0x10, then reads 0x10 → `o_m1_gnt` = 1 both cycles. One cycle after the read, `o_m1_rvalid` = 1 and `o_m1_rdata` = 0xDEADBEEF; `o_m0_rvalid` stays 0.
- **Contention:** MAX_BURST = 4, both masters request continuously → grant sequence m0 ×4, m1 ×1, repeating. `burst_cnt` never exceeds 4.
- **Alternation:** MAX_BURST = 1, both masters request continuously → grants strictly alternate m0/m1 every cycle.
- **Request withdrawal:** m1 requests for 3 contended cycles, drops `req` for 1 cycle, then requests again → `burst_cnt` restarts at 0, and m1 waits a full 4 more m0 grants.
- **Mixed traffic:** m0 writes 0x1 to 0x0 while m1 reads 0x0 in the same cycle → m0 is granted. m1 is granted the next cycle and reads 0x1 with `rvalid` one cycle later.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single data-memory port between the core load/store
//            path (master 0) and a host/DMA requester (master 1). Master 0 has
//            fixed priority. Master 1 is guaranteed a slot after at most
//            MAX_BURST consecutive master-0 grants while it waits. Read data is
//            returned to the winning master one cycle after its grant.
// Ports    : i_clk, i_rst_n           - clock, synchronous active-low reset
//            i_mN_req/we/addr/wdata   - master N request (level) and payload
//            o_mN_gnt                 - master N granted this cycle (comb)
//            o_mN_rvalid/rdata        - master N read return (registered)
//            o_mem_we/addr/wdata      - memory port drive (comb mux)
//            i_mem_rdata              - memory combinational read data
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   // master 0 : core load/store path
   input  logic              i_m0_req,
   input  logic              i_m0_we,
   input  logic [ADDR_W-1:0] i_m0_addr,
   input  logic [DATA_W-1:0] i_m0_wdata,
   output logic              o_m0_gnt,
   output logic              o_m0_rvalid,
   output logic [DATA_W-1:0] o_m0_rdata,
   // master 1 : host / DMA
   input  logic              i_m1_req,
   input  logic              i_m1_we,
   input  logic [ADDR_W-1:0] i_m1_addr,
   input  logic [DATA_W-1:0] i_m1_wdata,
   output logic              o_m1_gnt,
   output logic              o_m1_rvalid,
   output logic [DATA_W-1:0] o_m1_rdata,
   // shared memory port
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   // Burst limit forced into the 4-bit counter's legal range 1..15 so an
   // out-of-range parameter can never lock master 1 out or overflow.
   localparam logic [3:0] c_MAX_BURST = (MAX_BURST < 1)  ? 4'd1  :
                                        (MAX_BURST > 15) ? 4'd15 :
                                        4'(MAX_BURST);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [3:0]        burst_cnt_q, burst_cnt_d;
   logic              m0_rvalid_q, m0_rvalid_d;
   logic              m1_rvalid_q, m1_rvalid_d;
   logic [DATA_W-1:0] m0_rdata_q,  m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q,  m1_rdata_d;

   logic              w_m1_turn;
   logic              w_m0_gnt;
   logic              w_m1_gnt;

   // ------------------------------------------------------------------------
   // Grant decision
   // ------------------------------------------------------------------------
   // Master 1 takes the port under contention only once master 0 has used
   // its full burst allowance. Both grants are gated by reset so nothing can
   // reach memory while the block is held in reset.
   always_comb begin
      w_m1_turn = (burst_cnt_q >= c_MAX_BURST);
      w_m0_gnt  = i_rst_n & i_m0_req & (~i_m1_req | ~w_m1_turn);
      w_m1_gnt  = i_rst_n & i_m1_req & (~i_m0_req |  w_m1_turn);
   end

   assign o_m0_gnt = w_m0_gnt;
   assign o_m1_gnt = w_m1_gnt;

   // ------------------------------------------------------------------------
   // Memory port mux: idle port is driven to all zeros
   // ------------------------------------------------------------------------
   always_comb begin
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (w_m0_gnt) begin
         o_mem_we    = i_m0_we;
         o_mem_addr  = i_m0_addr;
         o_mem_wdata = i_m0_wdata;
      end else if (w_m1_gnt) begin
         o_mem_we    = i_m1_we;
         o_mem_addr  = i_m1_addr;
         o_mem_wdata = i_m1_wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Starvation counter
   // ------------------------------------------------------------------------
   // Counts master-0 grants taken while master 1 is waiting. Any cycle where
   // master 1 is not requesting (including a withdrawn request) or is served
   // restarts the count, so each new wait gets the full allowance.
   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if (!i_m1_req || w_m1_gnt) begin
         burst_cnt_d = 4'd0;
      end else if (w_m0_gnt && (burst_cnt_q < c_MAX_BURST)) begin
         burst_cnt_d = burst_cnt_q + 4'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Read return
   // ------------------------------------------------------------------------
   // rvalid pulses for the single cycle after a granted read; rdata only
   // updates on such a read and otherwise keeps the last returned word.
   always_comb begin
      m0_rvalid_d = w_m0_gnt & ~i_m0_we;
      m1_rvalid_d = w_m1_gnt & ~i_m1_we;
      m0_rdata_d  = m0_rvalid_d ? i_mem_rdata : m0_rdata_q;
      m1_rdata_d  = m1_rvalid_d ? i_mem_rdata : m1_rdata_q;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         burst_cnt_q <= 4'd0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         burst_cnt_q <= burst_cnt_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
      end
   end

   assign o_m0_rvalid = m0_rvalid_q;
   assign o_m1_rvalid = m1_rvalid_q;
   assign o_m0_rdata  = m0_rdata_q;
   assign o_m1_rdata  = m1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. Two instances (burst limit
//            4 and 1) share one directed stimulus stream; each has its own
//            memory array and its own reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        r0, we0, r1, we1;
   logic [31:0] a0, d0, a1, d1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // DUT A : MAX_BURST = 4
   logic        gA0, gA1, rvA0, rvA1, mweA;
   logic [31:0] rdA0, rdA1, maddrA, mwdA, mrdA;
   // DUT B : MAX_BURST = 1
   logic        gB0, gB1, rvB0, rvB1, mweB;
   logic [31:0] rdB0, rdB1, maddrB, mwdB, mrdB;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m0_req(r0), .i_m0_we(we0), .i_m0_addr(a0), .i_m0_wdata(d0),
      .o_m0_gnt(gA0), .o_m0_rvalid(rvA0), .o_m0_rdata(rdA0),
      .i_m1_req(r1), .i_m1_we(we1), .i_m1_addr(a1), .i_m1_wdata(d1),
      .o_m1_gnt(gA1), .o_m1_rvalid(rvA1), .o_m1_rdata(rdA1),
      .o_mem_we(mweA), .o_mem_addr(maddrA), .o_mem_wdata(mwdA),
      .i_mem_rdata(mrdA)
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m0_req(r0), .i_m0_we(we0), .i_m0_addr(a0), .i_m0_wdata(d0),
      .o_m0_gnt(gB0), .o_m0_rvalid(rvB0), .o_m0_rdata(rdB0),
      .i_m1_req(r1), .i_m1_we(we1), .i_m1_addr(a1), .i_m1_wdata(d1),
      .o_m1_gnt(gB1), .o_m1_rvalid(rvB1), .o_m1_rdata(rdB1),
      .o_mem_we(mweB), .o_mem_addr(maddrB), .o_mem_wdata(mwdB),
      .i_mem_rdata(mrdB)
   );

   // Word-addressed memories, 16 words each, combinational read
   logic [31:0] memA [16];
   logic [31:0] memB [16];
   assign mrdA = memA[maddrA[5:2]];
   assign mrdB = memB[maddrB[5:2]];
   always @(posedge clk) begin
      if (mweA) memA[maddrA[5:2]] <= mwdA;
      if (mweB) memB[maddrB[5:2]] <= mwdB;
   end

   // -------------------------------------------------------------------------
   // Checking helpers
   // -------------------------------------------------------------------------
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Reference model: per instance, "how many times in a row has m0 been
   // served while m1 was waiting", plus a shadow memory and the read word
   // each master must see on the cycle after its read.
   // -------------------------------------------------------------------------
   int          mx  [2] = '{4, 1};
   int          cnt [2] = '{0, 0};
   logic        erv0[2] = '{1'b0, 1'b0};
   logic        erv1[2] = '{1'b0, 1'b0};
   logic [31:0] erd0[2] = '{32'h0, 32'h0};
   logic [31:0] erd1[2] = '{32'h0, 32'h0};
   logic [31:0] smem[2][16];

   task automatic model_step(input int k, input string tag,
                             input logic g0, input logic g1, input logic mwe,
                             input logic [31:0] madr, input logic [31:0] mwd,
                             input logic rv0, input logic rv1,
                             input logic [31:0] rd0, input logic [31:0] rd1);
      logic        e0, e1, ew;
      logic [31:0] ea, ed;
      if (!rst_n) begin
         e0 = 1'b0; e1 = 1'b0;
      end else if (r0 && r1) begin
         e1 = (cnt[k] >= mx[k]);
         e0 = !e1;
      end else begin
         e0 = r0; e1 = r1;
      end
      ew = 1'b0; ea = 32'h0; ed = 32'h0;
      if (e0) begin
         ew = we0; ea = a0; ed = d0;
      end else if (e1) begin
         ew = we1; ea = a1; ed = d1;
      end

      chk({tag, ".gnt0"},     32'(g0),   32'(e0));
      chk({tag, ".gnt1"},     32'(g1),   32'(e1));
      chk({tag, ".mem_we"},   32'(mwe),  32'(ew));
      chk({tag, ".mem_addr"}, madr,      ea);
      chk({tag, ".mem_wdata"},mwd,       ed);
      chk({tag, ".rvalid0"},  32'(rv0),  32'(erv0[k]));
      chk({tag, ".rvalid1"},  32'(rv1),  32'(erv1[k]));
      chk({tag, ".rdata0"},   rd0,       erd0[k]);
      chk({tag, ".rdata1"},   rd1,       erd1[k]);
      chk({tag, ".rv_excl"},  32'(rv0 & rv1), 32'h0);

      // advance to the state after the coming rising edge
      if (!rst_n) begin
         cnt[k] = 0;
         erv0[k] = 1'b0; erv1[k] = 1'b0;
         erd0[k] = 32'h0; erd1[k] = 32'h0;
      end else begin
         erv0[k] = e0 && !we0;
         erv1[k] = e1 && !we1;
         if (erv0[k]) erd0[k] = smem[k][a0[5:2]];
         if (erv1[k]) erd1[k] = smem[k][a1[5:2]];
         if (e0 && we0) smem[k][a0[5:2]] = d0;
         if (e1 && we1) smem[k][a1[5:2]] = d1;
         if (!r1 || e1)                 cnt[k] = 0;
         else if (e0 && cnt[k] < mx[k]) cnt[k] = cnt[k] + 1;
      end
   endtask

   always @(negedge clk) begin
      model_step(0, "A", gA0, gA1, mweA, maddrA, mwdA, rvA0, rvA1, rdA0, rdA1);
      model_step(1, "B", gB0, gB1, mweB, maddrB, mwdB, rvB0, rvB1, rdB0, rdB1);
   end

   // -------------------------------------------------------------------------
   // Stimulus: inputs change 1 time unit after the rising edge, then the
   // caller samples at the falling edge.
   // -------------------------------------------------------------------------
   task automatic cyc(input logic rs,
                      input logic q0, input logic w0, input logic [31:0] ad0, input logic [31:0] dt0,
                      input logic q1, input logic w1, input logic [31:0] ad1, input logic [31:0] dt1);
      @(posedge clk);
      #1;
      rst_n = rs;
      r0 = q0; we0 = w0; a0 = ad0; d0 = dt0;
      r1 = q1; we1 = w1; a1 = ad1; d1 = dt1;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         memA[i] = 32'h0; memB[i] = 32'h0;
         smem[0][i] = 32'h0; smem[1][i] = 32'h0;
      end
      // reset held with both masters trying to write
      rst_n = 1'b0;
      r0 = 1'b1; we0 = 1'b1; a0 = 32'h8; d0 = 32'h55;
      r1 = 1'b1; we1 = 1'b1; a1 = 32'hC; d1 = 32'h66;

      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 32'h8, 32'h55, 1'b1, 1'b1, 32'hC, 32'h66);
         chk("rst.gnt0", 32'(gA0), 32'h0);
         chk("rst.gnt1", 32'(gA1), 32'h0);
         chk("rst.mem_we", 32'(mweA), 32'h0);
      end
      // read request while still in reset: must not return data afterwards
      cyc(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("rst.mem_unchanged8", memA[2], 32'h0);
      chk("rst.mem_unchangedC", memA[3], 32'h0);

      // first cycle out of reset: m0 wins
      cyc(1'b1, 1'b1, 1'b1, 32'h8, 32'h55, 1'b1, 1'b1, 32'hC, 32'h66);
      chk("rel.gnt0", 32'(gA0), 32'h1);
      chk("rel.gnt1", 32'(gA1), 32'h0);
      chk("rel.rvalid0", 32'(rvA0), 32'h0);
      idle();

      // single master: m1 writes then reads 0x10
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      chk("single.wr_gnt1", 32'(gA1), 32'h1);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
      chk("single.rd_gnt1", 32'(gA1), 32'h1);
      idle();
      chk("single.rvalid1", 32'(rvA1), 32'h1);
      chk("single.rdata1", rdA1, 32'hDEADBEEF);
      chk("single.rvalid0", 32'(rvA0), 32'h0);
      idle();

      // continuous contention: A grants m1 every 5th cycle, B alternates
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
         chk("cont.A_gnt1", 32'(gA1), 32'((i % 5) == 4));
         chk("cont.A_gnt0", 32'(gA0), 32'((i % 5) != 4));
         chk("cont.B_gnt1", 32'(gB1), 32'((i % 2) == 1));
         if (i == 5) begin
            chk("cont.A_rvalid1", 32'(rvA1), 32'h1);
            chk("cont.A_rdata1", rdA1, 32'hDEADBEEF);
         end
         if (i == 2) chk("cont.A_rdata0", rdA0, 32'h55);
      end
      idle();

      // withdrawal: 3 contended cycles, m1 drops for one, then a full wait
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
         chk("wd.pre_gnt0", 32'(gA0), 32'h1);
      end
      cyc(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h10, 32'h0);
      chk("wd.drop_gnt0", 32'(gA0), 32'h1);
      for (int j = 0; j < 5; j++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
         chk("wd.post_gnt1", 32'(gA1), 32'(j == 4));
      end
      idle();

      // mixed: m0 writes 1 to 0x0 while m1 reads 0x0
      cyc(1'b1, 1'b1, 1'b1, 32'h0, 32'h1, 1'b1, 1'b0, 32'h0, 32'h0);
      chk("mix.gnt0", 32'(gA0), 32'h1);
      chk("mix.gnt1", 32'(gA1), 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
      chk("mix.gnt1_next", 32'(gA1), 32'h1);
      idle();
      chk("mix.A_rvalid1", 32'(rvA1), 32'h1);
      chk("mix.A_rdata1", rdA1, 32'h1);
      chk("mix.B_rdata1", rdB1, 32'h1);
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
